sha256_1024in: RTL and testbench
================================

Name: sha256_1024in

Overview:
- Fixed-size SHA-256 engine that hashes one 1024-bit input as exactly two consecutive 512-bit blocks, starting from the standard SHA-256 initial hash value.
- The caller supplies pre-padded input; the block does no padding.
- Used by the HMAC wrapper for both the inner hash (ipad-key‖message) and the outer hash (opad-key‖inner digest).
- Input and output each use a valid/ready handshake; one hash in flight at a time.

Parameters:
- none

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word present
- in  in  1024  pre-padded message; block0 = in[1023:512], block1 = in[511:0]
- in_ready  out  1  engine idle, can accept input
- out_valid  out  1  digest available
- out  out  256  digest; H0 in out[255:224] … H7 in out[31:0]
- out_ready  in  1  consumer takes digest

Behaviour:
- States: IDLE, BLK0, BLK1, DONE.
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, out=0, round counter=0, working/hash registers=0.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: capture in; load H0..H7 and a..h with the IV 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19; round=0; go BLK0.
- BLK0/BLK1:
  - in_ready=0; in_valid ignored.
  - One compression round per cycle, rounds 0..63, standard K constants.
  - Message schedule uses a 16-word sliding window. W0 is the MSB word of the block: in[1023:992] for block0, in[511:480] for block1.
  - Words are big-endian; all additions are mod 2^32.
- At round 63 of BLK0:
  - Hi <= Hi + (round-63 result), i = 0..7.
  - a..h <= the same sums.
  - round=0; go BLK1.
- At round 63 of BLK1:
  - Hi <= Hi + result; out <= concatenated sums; go DONE.
- Latency: out_valid rises exactly 128 cycles after the acceptance edge.
- DONE:
  - out_valid=1; in_ready=0.
  - out stable until the next digest is written.
  - On an edge with out_ready=1: go IDLE, out_valid=0.
  - A new input can be accepted no earlier than the following cycle.
- out_ready while not in DONE: ignored.
- out retains its last digest in IDLE and while busy; it is not cleared except by reset.
- Reset mid-hash: immediately abort to IDLE and clear outputs; no partial digest is ever presented.
- in is sampled only at the acceptance edge; later changes to in have no effect on the hash in progress.
- Handshake signals are combinational from state only:
  - in_ready = IDLE
  - out_valid = DONE
  - No combinational path from in_valid or out_ready to any output.

Test Plan:
- 2-block NIST vector:
  - in = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits), then 0x80, zeros to bit 512; block1 = zeros with last 64 bits = 0x1C0.
  - Hold in_valid=1, out_ready=1.
  - Required: out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, out_valid 128 cycles after acceptance.
- Backpressure:
  - Same vector with out_ready=0 for 20 cycles after out_valid.
  - Required: out_valid and out held stable; the handshake completes on the first edge with out_ready=1; in_ready=1 on the next cycle.
- Busy rejection:
  - Toggle in_valid and change in during BLK0/BLK1.
  - Required: in_ready=0 throughout; the digest equals the originally captured vector's value.
- Back-to-back: run two hashes of the same vector with in_valid held high. Required:
  - Both digests identical.
  - The second acceptance occurs one cycle after the first output handshake.
- Reset mid-operation:
  - Assert rst_i asynchronously at round 40 of BLK1.
  - Required: out_valid=0, in_ready=1, out=0 immediately; a subsequent run of the vector produces the correct digest.
- All-zero input:
  - in=0.
  - Required: the digest matches a software SHA-256 two-block compression of 1024 zero bits with no padding (bench computes it via its reference model); latency 128 cycles.

Source files
------------

// File: rtl/sha256_1024in.sv
// ============================================================================
// sha256_1024in
// ----------------------------------------------------------------------------
// Fixed-size SHA-256 engine. It hashes one pre-padded 1024-bit input as two
// consecutive 512-bit blocks, starting from the standard SHA-256 IV. The
// engine runs one compression round per clock, so a digest appears 128
// cycles after the input is accepted. Only one hash is in flight at a time.
// The HMAC wrapper uses it for both the inner and the outer hash.
//
// Ports:
//   clk_i      in   1     clock, all state updates on the rising edge
//   rst_i      in   1     asynchronous active-high reset
//   in_valid   in   1     input word present
//   in         in   1024  pre-padded message, block0 = in[1023:512],
//                         block1 = in[511:0]
//   in_ready   out  1     engine idle, input accepted on in_valid
//   out_valid  out  1     digest available
//   out        out  256   digest, H0 in out[255:224] ... H7 in out[31:0]
//   out_ready  in   1     consumer takes the digest
// ============================================================================
module sha256_1024in (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid,
    input  logic [1023:0] in,
    output logic          in_ready,
    output logic          out_valid,
    output logic [255:0]  out,
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, BLK0, BLK1, DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t       state;
    logic [5:0]   round;
    logic [31:0]  hash [8];
    logic [31:0]  work [8];
    logic [31:0]  win  [16];
    logic [511:0] blk1;

    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [31:0]  w_next;
    logic [31:0]  work_next [8];
    logic [31:0]  hash_sum  [8];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // The handshake outputs are pure decodes of the state register, so
    // neither in_valid nor out_ready can reach an output combinationally.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One SHA-256 round. work[0..7] hold a..h, win[0] is W for the current
    // round and the sliding window always holds W[r]..W[r+15], so the word
    // W[r+16] is derived from the window and shifted in at the top. The
    // per-word sums with H are formed here too; they are only consumed on
    // the last round of a block.
    always_comb begin
        t1 = work[7]
           + (rotr(work[4], 6) ^ rotr(work[4], 11) ^ rotr(work[4], 25))
           + ((work[4] & work[5]) ^ (~work[4] & work[6]))
           + K[round]
           + win[0];
        t2 = (rotr(work[0], 2) ^ rotr(work[0], 13) ^ rotr(work[0], 22))
           + ((work[0] & work[1]) ^ (work[0] & work[2]) ^ (work[1] & work[2]));

        work_next[0] = t1 + t2;
        work_next[1] = work[0];
        work_next[2] = work[1];
        work_next[3] = work[2];
        work_next[4] = work[3] + t1;
        work_next[5] = work[4];
        work_next[6] = work[5];
        work_next[7] = work[6];

        w_next = (rotr(win[14], 17) ^ rotr(win[14], 19) ^ (win[14] >> 10))
               + win[9]
               + (rotr(win[1], 7) ^ rotr(win[1], 18) ^ (win[1] >> 3))
               + win[0];

        for (int i = 0; i < 8; i++) begin
            hash_sum[i] = hash[i] + work_next[i];
        end
    end

    // Control and datapath state. Block0 goes straight into the schedule
    // window at acceptance; block1 is parked in blk1 until block0 finishes,
    // so later changes on the in port cannot disturb the hash in progress.
    // After block0 the working registers restart from the updated H rather
    // than from the IV. The digest register is written only at the end of
    // block1, which keeps out stable in IDLE and while busy and guarantees
    // that an aborted hash never shows a partial result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            round <= '0;
            out   <= '0;
            blk1  <= '0;
            for (int i = 0; i < 8; i++) begin
                hash[i] <= '0;
                work[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        blk1  <= in[511:0];
                        round <= '0;
                        for (int i = 0; i < 8; i++) begin
                            hash[i] <= IV[i];
                            work[i] <= IV[i];
                        end
                        for (int i = 0; i < 16; i++) begin
                            win[i] <= in[1023 - 32*i -: 32];
                        end
                        state <= BLK0;
                    end
                end
                BLK0, BLK1: begin
                    round <= round + 6'd1;
                    for (int i = 0; i < 8; i++) begin
                        work[i] <= work_next[i];
                    end
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i + 1];
                    end
                    win[15] <= w_next;
                    if (round == 6'd63) begin
                        round <= '0;
                        for (int i = 0; i < 8; i++) begin
                            hash[i] <= hash_sum[i];
                            work[i] <= hash_sum[i];
                        end
                        if (state == BLK0) begin
                            for (int i = 0; i < 16; i++) begin
                                win[i] <= blk1[511 - 32*i -: 32];
                            end
                            state <= BLK1;
                        end else begin
                            out <= {hash_sum[0], hash_sum[1], hash_sum[2], hash_sum[3],
                                    hash_sum[4], hash_sum[5], hash_sum[6], hash_sum[7]};
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_1024in.sv
// ============================================================================
// tb_sha256_1024in
// ----------------------------------------------------------------------------
// Directed bench for sha256_1024in. Expected digests are queued when an
// input is offered and popped when the engine presents a digest. The NIST
// two-block vector uses its published digest; the all-zero input uses the
// bench's own SHA-256 compression model.
// ============================================================================
module tb_sha256_1024in;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] NIST_DIGEST =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic          clk_i;
    logic          rst_i;
    logic          in_valid;
    logic [1023:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [255:0]  out_data;
    logic          out_ready;

    int            checks;
    int            errors;
    logic [255:0]  sb [$];

    logic [447:0]  nist_msg;
    logic [1023:0] nist_vec;
    logic [255:0]  zero_digest;

    sha256_1024in dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in        (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out       (out_data),
        .out_ready (out_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straightforward reference: expand all 64 schedule words per block,
    // then run the textbook compression loop, two blocks, no padding.
    function automatic logic [255:0] refHash(input logic [1023:0] msg);
        logic [31:0] hv [8];
        logic [31:0] w  [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, tt1, tt2;
        hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int blk = 0; blk < 2; blk++) begin
            for (int t = 0; t < 16; t++) begin
                w[t] = msg[1023 - 512*blk - 32*t -: 32];
            end
            for (int t = 16; t < 64; t++) begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
            e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
            for (int t = 0; t < 64; t++) begin
                tt1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
                    + ((e & f) ^ (~e & g)) + KT[t] + w[t];
                tt2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
                    + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + tt1;
                d = c; c = b; b = a; a = tt1 + tt2;
            end
            hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
            hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string tag, input logic [255:0] observed,
                               input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Offers one input on a falling edge, queues its expected digest and
    // returns just after the acceptance edge. With hold=0 in_valid drops
    // right after acceptance.
    task automatic applyStimulus(input logic [1023:0] data, input logic [255:0] expected,
                                 input bit hold);
        @(negedge clk_i);
        in_data  = data;
        in_valid = 1'b1;
        sb.push_back(expected);
        checkOutput("in_ready_before_accept", {255'd0, in_ready}, 256'd1);
        @(posedge clk_i);
        #1;
        if (!hold) in_valid = 1'b0;
        checkOutput("in_ready_after_accept", {255'd0, in_ready}, 256'd0);
    endtask

    // Called right after acceptance. Checks the exact 128-cycle latency,
    // optionally scrambles in/in_valid while busy, optionally holds off the
    // consumer for 'stall' cycles, and returns just after the output
    // handshake edge.
    task automatic waitDigest(input string tag, input int stall, input bit disturb);
        logic [1023:0] junk;
        logic [255:0]  held;
        logic [255:0]  expected;
        out_ready = (stall == 0);
        for (int k = 0; k < 127; k++) begin
            @(posedge clk_i);
            #1;
            if (disturb) begin
                for (int j = 0; j < 32; j++) junk[32*j +: 32] = $urandom;
                in_data  = junk;
                in_valid = $urandom_range(0, 1) == 1;
                checkOutput({tag, "_busy_in_ready"}, {255'd0, in_ready}, 256'd0);
            end
        end
        if (disturb) in_valid = 1'b0;
        @(negedge clk_i);
        checkOutput({tag, "_valid_not_early"}, {255'd0, out_valid}, 256'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput({tag, "_valid_at_128"}, {255'd0, out_valid}, 256'd1);
        expected = (sb.size() > 0) ? sb.pop_front() : 'x;
        checkOutput({tag, "_digest"}, out_data, expected);
        held = out_data;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk_i);
            #1;
            checkOutput({tag, "_stall_valid"}, {255'd0, out_valid}, 256'd1);
            checkOutput({tag, "_stall_out"}, out_data, held);
        end
        out_ready = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput({tag, "_valid_dropped"}, {255'd0, out_valid}, 256'd0);
        checkOutput({tag, "_in_ready_back"}, {255'd0, in_ready}, 256'd1);
        checkOutput({tag, "_out_retained"}, out_data, held);
    endtask

    // Directed sequence: reset, NIST vector back-to-back, backpressure with
    // busy scrambling, reset at BLK1 round 40, then the all-zero input.
    initial begin
        checks    = 0;
        errors    = 0;
        rst_i     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        nist_msg  = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        nist_vec  = {nist_msg, 8'h80, 56'd0, 448'd0, 64'h1C0};
        zero_digest = refHash(1024'd0);

        #12;
        checkOutput("reset_in_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("reset_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("reset_out", out_data, 256'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        $display("[TB] NIST vector, then back-to-back repeat");
        applyStimulus(nist_vec, NIST_DIGEST, 1'b1);
        waitDigest("nist", 0, 1'b0);
        applyStimulus(nist_vec, NIST_DIGEST, 1'b0);
        waitDigest("b2b", 0, 1'b0);

        $display("[TB] Backpressure with busy input scrambling");
        applyStimulus(nist_vec, NIST_DIGEST, 1'b0);
        waitDigest("bp_busy", 20, 1'b1);

        $display("[TB] Reset at BLK1 round 40");
        applyStimulus(nist_vec, NIST_DIGEST, 1'b0);
        repeat (104) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {255'd0, out_valid}, 256'd0);
        checkOutput("midrst_in_ready", {255'd0, in_ready}, 256'd1);
        checkOutput("midrst_out", out_data, 256'd0);
        sb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(nist_vec, NIST_DIGEST, 1'b0);
        waitDigest("after_rst", 0, 1'b0);

        $display("[TB] All-zero input");
        applyStimulus(1024'd0, zero_digest, 1'b0);
        waitDigest("zero", 0, 1'b0);

        checkOutput("scoreboard_empty", 256'(sb.size()), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
